// File: rtl/core_pc_predict.sv
// Fetch-PC generator with a direct-mapped BTB and 2-bit saturating counters.
// Resolves control flow from EX and redirects fetch on a misprediction.
module core_pc_predict #(
    parameter int              XLEN         = 32,
    parameter int              BTB_DEPTH    = 16,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [1:0]      CTR_INIT     = 2'b10,
    parameter bit              ENABLE_PRED  = 1'b1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            STALL,
    output logic [XLEN-1:0] PC,
    output logic            PRED_TAKEN,
    output logic [XLEN-1:0] PRED_TARGET,
    input  logic            EX_VALID,
    input  logic [XLEN-1:0] EX_PC,
    input  logic [XLEN-1:0] EX_IMM,
    input  logic [XLEN-1:0] EX_RS1,
    input  logic            EX_ISBRANCH,
    input  logic            EX_ISJAL,
    input  logic            EX_ISJALR,
    input  logic            EX_TAKE_BRANCH,
    input  logic            EX_PRED_TAKEN,
    input  logic [XLEN-1:0] EX_PRED_TARGET,
    output logic            FLUSH
);

    localparam int IDX  = $clog2(BTB_DEPTH);
    localparam int TAGW = XLEN - IDX - 2;

    logic [XLEN-1:0] r_pc;
    logic            r_valid  [BTB_DEPTH];
    logic [TAGW-1:0] r_tag    [BTB_DEPTH];
    logic [XLEN-1:0] r_target [BTB_DEPTH];
    logic [1:0]      r_ctr    [BTB_DEPTH];
    logic            r_jmp    [BTB_DEPTH];

    // Fetch-side lookup on the current PC
    logic [IDX-1:0]  w_f_idx;
    logic [TAGW-1:0] w_f_tag;
    logic            w_f_hit;

    assign w_f_idx = r_pc[IDX+1:2];
    assign w_f_tag = r_pc[XLEN-1:IDX+2];
    assign w_f_hit = ENABLE_PRED && r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);

    assign PC          = r_pc;
    assign PRED_TAKEN  = w_f_hit && (r_jmp[w_f_idx] || r_ctr[w_f_idx][1]);
    assign PRED_TARGET = w_f_hit ? r_target[w_f_idx] : '0;

    // EX-stage resolution
    logic [XLEN-1:0] w_br_target;
    logic [XLEN-1:0] w_jalr_target;
    logic [XLEN-1:0] w_act_target;
    logic [XLEN-1:0] w_act_next;
    logic            w_act_taken;
    logic            w_mispredict;

    assign w_br_target   = EX_PC + EX_IMM;
    assign w_jalr_target = (EX_RS1 + EX_IMM) & ~XLEN'(1);
    assign w_act_target  = EX_ISJALR ? w_jalr_target : w_br_target;
    assign w_act_taken   = EX_ISJAL || EX_ISJALR || (EX_ISBRANCH && EX_TAKE_BRANCH);
    assign w_act_next    = w_act_taken ? w_act_target : (EX_PC + XLEN'(4));
    assign w_mispredict  = (w_act_taken != EX_PRED_TAKEN) ||
                           (w_act_taken && (w_act_target != EX_PRED_TARGET));
    assign FLUSH         = !RST && EX_VALID && w_mispredict;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc <= RESET_VECTOR;
        end else if (FLUSH) begin
            r_pc <= w_act_next;
        end else if (!STALL) begin
            r_pc <= PRED_TAKEN ? PRED_TARGET : (r_pc + XLEN'(4));
        end
    end

    // Update-side lookup on EX_PC; independent of STALL
    logic [IDX-1:0]  w_u_idx;
    logic [TAGW-1:0] w_u_tag;
    logic            w_u_hit;
    logic            w_u_en;
    logic [1:0]      w_u_ctr;
    logic [1:0]      w_ctr_inc;
    logic [1:0]      w_ctr_dec;

    assign w_u_idx   = EX_PC[IDX+1:2];
    assign w_u_tag   = EX_PC[XLEN-1:IDX+2];
    assign w_u_hit   = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
    assign w_u_en    = ENABLE_PRED && EX_VALID && !RST;
    assign w_u_ctr   = r_ctr[w_u_idx];
    assign w_ctr_inc = (w_u_ctr == 2'b11) ? 2'b11 : w_u_ctr + 2'b01;
    assign w_ctr_dec = (w_u_ctr == 2'b00) ? 2'b00 : w_u_ctr - 2'b01;

    // Valid bits are the only BTB state that needs reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (w_u_en && !w_u_hit && w_act_taken) begin
            r_valid[w_u_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_u_en) begin
            if (w_u_hit) begin
                if (w_act_taken) begin
                    r_ctr[w_u_idx]    <= w_ctr_inc;
                    r_target[w_u_idx] <= w_act_target;
                end else begin
                    r_ctr[w_u_idx]    <= w_ctr_dec;
                end
            end else if (w_act_taken) begin
                r_tag[w_u_idx]    <= w_u_tag;
                r_target[w_u_idx] <= w_act_target;
                r_ctr[w_u_idx]    <= CTR_INIT;
                r_jmp[w_u_idx]    <= EX_ISJAL || EX_ISJALR;
            end
        end
    end

endmodule

// File: tb/tb_core_pc_predict.sv
// Directed table-driven bench for core_pc_predict: one vector per clock,
// combinational outputs checked mid-cycle, then a hand-written reset sequence.
module tb_core_pc_predict;

    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_BR   = 2'd1;
    localparam logic [1:0] K_JAL  = 2'd2;
    localparam logic [1:0] K_JALR = 2'd3;

    logic        CLK;
    logic        RST;
    logic        STALL;
    logic [31:0] PC;
    logic        PRED_TAKEN;
    logic [31:0] PRED_TARGET;
    logic        EX_VALID;
    logic [31:0] EX_PC;
    logic [31:0] EX_IMM;
    logic [31:0] EX_RS1;
    logic        EX_ISBRANCH;
    logic        EX_ISJAL;
    logic        EX_ISJALR;
    logic        EX_TAKE_BRANCH;
    logic        EX_PRED_TAKEN;
    logic [31:0] EX_PRED_TARGET;
    logic        FLUSH;

    core_pc_predict #(
        .XLEN         (32),
        .BTB_DEPTH    (16),
        .RESET_VECTOR (32'h0000_0100),
        .CTR_INIT     (2'b10),
        .ENABLE_PRED  (1'b1)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .STALL          (STALL),
        .PC             (PC),
        .PRED_TAKEN     (PRED_TAKEN),
        .PRED_TARGET    (PRED_TARGET),
        .EX_VALID       (EX_VALID),
        .EX_PC          (EX_PC),
        .EX_IMM         (EX_IMM),
        .EX_RS1         (EX_RS1),
        .EX_ISBRANCH    (EX_ISBRANCH),
        .EX_ISJAL       (EX_ISJAL),
        .EX_ISJALR      (EX_ISJALR),
        .EX_TAKE_BRANCH (EX_TAKE_BRANCH),
        .EX_PRED_TAKEN  (EX_PRED_TAKEN),
        .EX_PRED_TARGET (EX_PRED_TARGET),
        .FLUSH          (FLUSH)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        exv;
        logic [1:0]  kind;
        logic [31:0] ex_pc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic        tk;
        logic        ptk;
        logic [31:0] ptgt;
        logic        chk;
        logic [31:0] e_pc;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_fl;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[32];

    function automatic vec_t mk(input logic rst, input logic stall, input logic exv,
                                input logic [1:0] kind, input logic [31:0] ex_pc,
                                input logic [31:0] imm, input logic [31:0] rs1,
                                input logic tk, input logic ptk, input logic [31:0] ptgt,
                                input logic chk, input logic [31:0] e_pc, input logic e_pt,
                                input logic [31:0] e_ptgt, input logic e_fl);
        vec_t v;
        v.rst = rst;   v.stall = stall; v.exv = exv;   v.kind = kind;
        v.ex_pc = ex_pc; v.imm = imm;   v.rs1 = rs1;   v.tk = tk;
        v.ptk = ptk;   v.ptgt = ptgt;   v.chk = chk;   v.e_pc = e_pc;
        v.e_pt = e_pt; v.e_ptgt = e_ptgt; v.e_fl = e_fl;
        return v;
    endfunction

    function automatic vec_t idle(input logic stall, input logic [31:0] e_pc,
                                  input logic e_pt, input logic [31:0] e_ptgt);
        return mk(1'b0, stall, 1'b0, K_NONE, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                  1'b1, e_pc, e_pt, e_ptgt, 1'b0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        RST            = v.rst;
        STALL          = v.stall;
        EX_VALID       = v.exv;
        EX_PC          = v.ex_pc;
        EX_IMM         = v.imm;
        EX_RS1         = v.rs1;
        EX_ISBRANCH    = (v.kind == K_BR);
        EX_ISJAL       = (v.kind == K_JAL);
        EX_ISJALR      = (v.kind == K_JALR);
        EX_TAKE_BRANCH = v.tk;
        EX_PRED_TAKEN  = v.ptk;
        EX_PRED_TARGET = v.ptgt;
    endtask

    task automatic apply(input int idx, input vec_t v);
        drive(v);
        #2;
        n_vec++;
        check($sformatf("v%0d flush", idx), {31'b0, FLUSH}, {31'b0, v.e_fl});
        if (v.chk) begin
            check($sformatf("v%0d pc", idx), PC, v.e_pc);
            check($sformatf("v%0d pred_taken", idx), {31'b0, PRED_TAKEN}, {31'b0, v.e_pt});
            check($sformatf("v%0d pred_target", idx), PRED_TARGET, v.e_ptgt);
        end
        $display("vec %0d: rst=%b stall=%b pc=%h pred=%b/%h flush=%b",
                 idx, v.rst, v.stall, PC, PRED_TAKEN, PRED_TARGET, FLUSH);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset with a would-be mispredict in EX: FLUSH forced low, update dropped
        vecs[0]  = mk(1, 0, 1, K_BR,   32'h40,  32'hFFFF_FFF0, 0,      1, 0, 0,      0, 32'h0,   0, 0,       0);
        vecs[1]  = idle(0, 32'h100, 0, 0);
        vecs[2]  = idle(0, 32'h104, 0, 0);
        vecs[3]  = idle(0, 32'h108, 0, 0);
        vecs[4]  = mk(0, 0, 1, K_JAL,  32'h3C,  32'h4,         0,      0, 0, 0,      1, 32'h10C, 0, 0,       1);
        vecs[5]  = idle(0, 32'h40, 0, 0);
        vecs[6]  = mk(0, 0, 1, K_BR,   32'h40,  32'hFFFF_FFF0, 0,      1, 0, 0,      1, 32'h44,  0, 0,       1);
        vecs[7]  = idle(0, 32'h30, 0, 0);
        vecs[8]  = idle(0, 32'h34, 0, 0);
        vecs[9]  = idle(0, 32'h38, 0, 0);
        vecs[10] = idle(0, 32'h3C, 1, 32'h40);
        vecs[11] = idle(0, 32'h40, 1, 32'h30);
        vecs[12] = mk(0, 0, 1, K_BR,   32'h40,  32'hFFFF_FFF0, 0,      0, 1, 32'h30, 1, 32'h30,  0, 0,       1);
        vecs[13] = mk(0, 0, 1, K_BR,   32'h40,  32'hFFFF_FFF0, 0,      0, 0, 0,      1, 32'h44,  0, 0,       0);
        vecs[14] = mk(0, 0, 1, K_JALR, 32'h204, 32'h2,         32'h3F, 0, 0, 0,      1, 32'h48,  0, 0,       1);
        vecs[15] = idle(0, 32'h40, 0, 32'h30);
        vecs[16] = mk(0, 0, 1, K_JALR, 32'h204, 32'h4,         32'h201, 0, 1, 32'h204, 1, 32'h44, 0, 0,      0);
        vecs[17] = mk(0, 0, 1, K_JALR, 32'h204, 32'h4,         32'h300, 0, 1, 32'h204, 1, 32'h48, 0, 0,      1);
        vecs[18] = mk(0, 1, 1, K_JAL,  32'h1F0, 32'h14,        0,      0, 0, 0,      1, 32'h304, 0, 0,       1);
        vecs[19] = idle(1, 32'h204, 1, 32'h304);
        vecs[20] = idle(1, 32'h204, 1, 32'h304);
        vecs[21] = idle(1, 32'h204, 1, 32'h304);
        vecs[22] = idle(0, 32'h204, 1, 32'h304);
        vecs[23] = mk(0, 0, 1, K_JAL,  32'h8,   32'hFFFF_FFF4, 0,      0, 0, 0,      1, 32'h304, 0, 0,       1);
        vecs[24] = idle(0, 32'hFFFF_FFFC, 0, 0);
        vecs[25] = mk(0, 0, 1, K_JAL,  32'h10,  32'h70,        0,      0, 0, 0,      1, 32'h0,   0, 0,       1);
        vecs[26] = mk(0, 0, 1, K_BR,   32'h80,  32'h100,       0,      1, 0, 0,      1, 32'h80,  0, 0,       1);
        vecs[27] = mk(0, 0, 1, K_JAL,  32'h14,  32'h2C,        0,      0, 0, 0,      1, 32'h180, 0, 0,       1);
        vecs[28] = mk(0, 0, 1, K_JAL,  32'h18,  32'h68,        0,      0, 0, 0,      1, 32'h40,  0, 0,       1);
        vecs[29] = idle(0, 32'h80, 1, 32'h180);
        vecs[30] = mk(0, 0, 0, K_JAL,  32'h0,   32'h500,       0,      0, 0, 0,      1, 32'h180, 0, 0,       0);
        vecs[31] = idle(0, 32'h184, 0, 0);

        for (int i = 0; i < 32; i++) begin
            apply(i, vecs[i]);
        end

        // Mid-run reset: redirect suppressed, BTB (0x80 entry) wiped
        drive(mk(1, 0, 1, K_JAL, 32'h184, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        n_vec++;
        check("rst flush", {31'b0, FLUSH}, 32'h0);
        $display("seq rst: flush=%b", FLUSH);
        @(posedge CLK);
        #1;
        drive(mk(0, 0, 1, K_JAL, 32'h7C, 32'h4, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        n_vec++;
        check("post-rst pc", PC, 32'h100);
        check("post-rst flush", {31'b0, FLUSH}, 32'h1);
        check("post-rst pred", {31'b0, PRED_TAKEN}, 32'h0);
        $display("seq post-rst: pc=%h flush=%b", PC, FLUSH);
        @(posedge CLK);
        #1;
        drive(idle(0, 0, 0, 0));
        #2;
        n_vec++;
        check("cleared pc", PC, 32'h80);
        check("cleared pred", {31'b0, PRED_TAKEN}, 32'h0);
        check("cleared target", PRED_TARGET, 32'h0);
        $display("seq cleared: pc=%h pred=%b/%h", PC, PRED_TAKEN, PRED_TARGET);
        @(posedge CLK);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/core_pc_predict.md
Name: core_pc_predict

Overview:
- Parametrised fetch-PC generator, the successor to the combinational next-PC mux.
- Holds the architectural fetch PC register and predicts taken control flow at fetch using a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Resolves the actual next PC from EX-stage results and raises FLUSH plus a redirect on misprediction.
- Sits between the IF stage (drives the instruction address) and the EX stage (receives resolved branch/JAL/JALR info).

Parameters:
- XLEN, 32, datapath/PC width.
- BTB_DEPTH, 16, number of BTB entries; power of 2, at least 2.
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- CTR_INIT, 2'b10, counter value on a new allocation (weakly taken).
- ENABLE_PRED, 1, 0 disables prediction: PRED_TAKEN is always 0 and the BTB is never written.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- STALL  in  1  hold fetch PC.
- PC  out  XLEN  current fetch PC (registered).
- PRED_TAKEN  out  1  prediction for PC; combinational from BTB lookup.
- PRED_TARGET  out  XLEN  predicted target for PC; valid when PRED_TAKEN=1.
- EX_VALID  in  1  a control-flow instruction is resolving in EX this cycle.
- EX_PC  in  XLEN  PC of the EX instruction.
- EX_IMM  in  XLEN  sign-extended immediate.
- EX_RS1  in  XLEN  rs1 read data (for JALR).
- EX_ISBRANCH  in  1  conditional branch.
- EX_ISJAL  in  1  JAL.
- EX_ISJALR  in  1  JALR.
- EX_TAKE_BRANCH  in  1  branch condition true.
- EX_PRED_TAKEN  in  1  prediction carried with the instruction from IF.
- EX_PRED_TARGET  in  XLEN  predicted target carried from IF.
- FLUSH  out  1  mispredict; kills younger instructions. Combinational.

Behaviour:
- All additions are mod 2^XLEN; wrap-around is silent.
- Resolution (combinational):
  - act_taken = EX_ISJAL | EX_ISJALR | (EX_ISBRANCH & EX_TAKE_BRANCH).
  - act_target = EX_PC+EX_IMM for branch/JAL; (EX_RS1+EX_IMM) & ~1 for JALR.
  - act_next = act_taken ? act_target : EX_PC+4.
- mispredict = (act_taken != EX_PRED_TAKEN) | (act_taken & act_target != EX_PRED_TARGET).
- FLUSH = EX_VALID & mispredict.
- Next-PC priority, registered on the CLK edge:
  - RST: RESET_VECTOR.
  - else FLUSH: act_next. FLUSH overrides STALL.
  - else STALL: hold PC.
  - else PRED_TAKEN: PRED_TARGET.
  - else PC+4.
- BTB entry fields: valid, tag PC[XLEN-1:IDX+2], target XLEN, ctr 2 bits, jmp 1 bit. IDX=log2(BTB_DEPTH); index = PC[IDX+1:2].
- Lookup: hit = valid & tag match. PRED_TAKEN = ENABLE_PRED & hit & (jmp | ctr[1]). PRED_TARGET = entry target; 0 on a miss.
- Update, on the edge when EX_VALID=1, ENABLE_PRED=1 and RST=0. Not gated by STALL. Indexed by EX_PC:
  - Hit with act_taken: increment ctr, saturating at 3; target <= act_target.
  - Hit with not taken: decrement ctr, saturating at 0.
  - Miss with act_taken: allocate/replace; valid=1, tag, target=act_target, ctr=CTR_INIT, jmp=EX_ISJAL|EX_ISJALR.
  - Miss with not taken: no write.
- Same-index lookup and update in one cycle: lookup returns pre-update contents; the write is visible next cycle.
- Reset:
  - All BTB valid bits cleared in one cycle; targets and counters are don't-care.
  - PC=RESET_VECTOR, PRED_TAKEN=0, PRED_TARGET=0.
  - FLUSH is forced to 0 while RST=1.
  - Reset mid-operation discards any in-flight update or redirect.
- Latency: redirect takes effect one cycle after FLUSH. A BTB update is usable for a lookup one cycle after the write edge.
- EX_VALID=0: FLUSH=0, no BTB write; EX inputs are ignored.

Test Plan:
- Reset then 3 unstalled cycles, RESET_VECTOR=0x100 -> PC = 0x100, 0x104, 0x108, 0x10C; PRED_TAKEN=0; FLUSH=0.
- Branch at EX_PC=0x40, EX_IMM=-16, taken, EX_PRED_TAKEN=0 -> FLUSH=1; next PC=0x30; BTB allocated with ctr=2. Later fetch at 0x40 -> PRED_TAKEN=1, PRED_TARGET=0x30.
- Same branch resolved not-taken twice -> first gives FLUSH=1 (redirect 0x44), ctr=1; second gives FLUSH=0 (pred not-taken), ctr=0; fetch at 0x40 -> PRED_TAKEN=0.
- JALR with EX_RS1=0x201, EX_IMM=4, predicted target 0x204 -> act_target=0x204, FLUSH=0. Then EX_RS1=0x300 -> FLUSH=1, next PC=0x304, BTB target updated.
- STALL=1 with FLUSH=1 at the same time -> PC takes act_next; STALL=1 alone for 3 cycles -> PC constant.
- PC=0xFFFF_FFFC, no prediction -> next PC=0x0000_0000. Two PCs aliasing one index (0x40, 0x80 with DEPTH=16) -> tag mismatch gives a miss; a taken allocation replaces the entry.
